// File: rtl/xaui_gtx_reset_seq.sv
// Reset/initialisation sequencer for one XAUI GTX group: PMA hold, lock wait, resetdone wait, user reset release.
// Optional lock-loss recovery out of READY is built when XAUI_RST_LOCKLOSS_EN is defined.
module xaui_gtx_reset_seq #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000,
  parameter logic [19:0] DONE_TIMEOUT = 20'd100000,
  parameter int unsigned USR_DELAY    = 8,
  parameter int unsigned LANES        = 4
) (
  input  logic             gtx_refclk_bufr,
  input  logic             mgt_reset,
  input  logic [LANES-1:0] pll_lock,
  input  logic [LANES-1:0] tx_resetdone,
  input  logic [LANES-1:0] rx_resetdone,
  output logic             pma_reset,
  output logic             usr_tx_rst,
  output logic             usr_rx_rst,
  output logic             ready,
  output logic [7:0]       retry_count,
  output logic [2:0]       seq_state
);

  localparam int unsigned TW = 20;
  localparam int unsigned RW = 8;
  localparam int unsigned SW = 3;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_READY     = 3'd4
  } state_e;

  logic [LANES-1:0] lock_meta_q, lock_s_q;
  logic [LANES-1:0] txd_meta_q, txd_s_q;
  logic [LANES-1:0] rxd_meta_q, rxd_s_q;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             pma_q, pma_d;
  logic             usr_rst_q, usr_rst_d;
  logic             ready_q, ready_d;
  logic [SW-1:0]    seq_q, seq_d;
  logic             restart_c;
  logic             all_lock_c;
  logic             all_done_c;

`ifdef XAUI_RST_LOCKLOSS_EN
  logic [1:0]       filt_q, filt_d;
`endif

  // Two-flop synchronisers for the asynchronous GTX status inputs
  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      lock_meta_q <= '0;
      lock_s_q    <= '0;
      txd_meta_q  <= '0;
      txd_s_q     <= '0;
      rxd_meta_q  <= '0;
      rxd_s_q     <= '0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      txd_meta_q  <= tx_resetdone;
      txd_s_q     <= txd_meta_q;
      rxd_meta_q  <= rx_resetdone;
      rxd_s_q     <= rxd_meta_q;
    end
  end

  assign all_lock_c = &lock_s_q;
  assign all_done_c = (&txd_s_q) & (&rxd_s_q);

  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      state_q   <= ST_HOLD;
      timer_q   <= '0;
      retry_q   <= '0;
      pma_q     <= 1'b1;
      usr_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      seq_q     <= '0;
`ifdef XAUI_RST_LOCKLOSS_EN
      filt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pma_q     <= pma_d;
      usr_rst_q <= usr_rst_d;
      ready_q   <= ready_d;
      seq_q     <= seq_d;
`ifdef XAUI_RST_LOCKLOSS_EN
      filt_q    <= filt_d;
`endif
    end
  end

  // Next state; every restart funnels through restart_c so coincident causes count once
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
`ifdef XAUI_RST_LOCKLOSS_EN
    filt_d    = '0;
`endif
    unique case (state_q)
      ST_HOLD: begin
        if (timer_q == TW'(HOLD_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (all_lock_c) state_d = ST_WAIT_DONE;
        else if (timer_q == LOCK_TIMEOUT - 20'd1) restart_c = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!all_lock_c) restart_c = 1'b1;
        else if (all_done_c) state_d = ST_RELEASE;
        else if (timer_q == DONE_TIMEOUT - 20'd1) restart_c = 1'b1;
      end
      ST_RELEASE: begin
        if (!all_lock_c) restart_c = 1'b1;
        else if (timer_q == TW'(USR_DELAY - 1)) state_d = ST_READY;
      end
      ST_READY: begin
`ifdef XAUI_RST_LOCKLOSS_EN
        if (!all_lock_c) begin
          if (filt_q == 2'd3) restart_c = 1'b1;
          else filt_d = filt_q + 2'd1;
        end
`endif
      end
      default: state_d = ST_HOLD;
    endcase

    if (restart_c) state_d = ST_HOLD;

    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    retry_d = (restart_c && (retry_q != 8'hFF)) ? retry_q + RW'(1) : retry_q;

    pma_d     = (state_q == ST_HOLD);
    usr_rst_d = (state_q != ST_READY);
    ready_d   = (state_q == ST_READY);
    seq_d     = SW'(state_q);
  end

  assign pma_reset   = pma_q;
  assign usr_tx_rst  = usr_rst_q;
  assign usr_rx_rst  = usr_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign seq_state   = seq_q;

endmodule
